arrival_stamper: RTL

Per-port ingress stage that writes a packet arrival timestamp into the AXI4-Stream TUSER sideband. The timestamp is read by the downstream per-port earliest-arrival arbiter. One instance sits on each input interface, between the RX queue and the arbiter's slave group port. It captures a free-running cycle counter when a packet's first beat is accepted and stamps that value on every beat of the packet. It provides full-throughput buffering with a two-entry skid register.

---
 rtl/arrival_stamper_if.sv | 24 ++
 rtl/arrival_stamper.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/arrival_stamper_if.sv
// arrival_stamper_if: AXI4-Stream beat bundle (tdata/tstrb/tuser/tlast plus valid/ready).
//   master modport: drives the beat and tvalid, samples tready.
//   slave  modport: samples the beat and tvalid, drives tready.
interface arrival_stamper_if #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned UserWidth = 128
) ();
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tstrb;
    logic [UserWidth-1:0]   tuser;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata, tstrb, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/arrival_stamper.sv
// arrival_stamper: per-port ingress stage that writes a packet arrival timestamp into TUSER.
// A free-running cycle counter is captured when the first beat of a packet is accepted and the
// same value is written into tuser[C_TS_POS +: C_TS_WIDTH] on every beat of that packet.
// A main + skid register pair gives full throughput with a registered s_axis.tready.
//
// Ports:
//   axi_aclk     clock
//   axi_aresetn  asynchronous active-low reset
//   sw_rst       synchronous active-high soft reset (same effect as reset)
//   s_axis       slave stream in (arrival_stamper_if.slave)
//   m_axis       stamped master stream out (arrival_stamper_if.master)
//   ts_now       current counter value
//
// Build option: define ARRIVAL_STAMPER_SATURATE_EN to make the counter stop at its maximum
// instead of wrapping, so stamps stay monotonic.
module arrival_stamper #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_TS_WIDTH           = 32,
    parameter int unsigned C_TS_POS             = 32
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    sw_rst,
    arrival_stamper_if.slave        s_axis,
    arrival_stamper_if.master       m_axis,
    output logic [C_TS_WIDTH-1:0]   ts_now
);

    localparam int unsigned StrbWidth = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [C_TS_WIDTH-1:0] TsOne = 1;
`ifdef ARRIVAL_STAMPER_SATURATE_EN
    localparam logic [C_TS_WIDTH-1:0] TsMax = '1;
`endif

    typedef enum logic [0:0] {StSop, StMid} pkt_state_e;

    typedef struct packed {
        logic [C_S_AXIS_DATA_WIDTH-1:0]  data;
        logic [StrbWidth-1:0]            strb;
        logic [C_S_AXIS_TUSER_WIDTH-1:0] user;
        logic                            last;
    } beat_t;

    logic [C_TS_WIDTH-1:0] ts_q, ts_d;
    logic [C_TS_WIDTH-1:0] stamp_q, stamp_d;
    logic [C_TS_WIDTH-1:0] cur_stamp;
    pkt_state_e            state_q, state_d;
    beat_t                 main_q, main_d;
    beat_t                 skid_q, skid_d;
    beat_t                 in_beat;
    logic                  main_vld_q, main_vld_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  rdy_q, rdy_d;
    logic                  accept;
    logic                  consume;

    always_comb begin
        accept  = s_axis.tvalid & rdy_q;
        consume = main_vld_q & m_axis.tready;

        // First beat takes the live counter; later beats reuse the captured value.
        cur_stamp = (state_q == StSop) ? ts_q : stamp_q;

        in_beat      = '0;
        in_beat.data = s_axis.tdata;
        in_beat.strb = s_axis.tstrb;
        in_beat.user = s_axis.tuser;
        in_beat.user[C_TS_POS +: C_TS_WIDTH] = cur_stamp;
        in_beat.last = s_axis.tlast;

        ts_d       = ts_q;
        stamp_d    = stamp_q;
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

`ifdef ARRIVAL_STAMPER_SATURATE_EN
        if (ts_q != TsMax) begin
            ts_d = ts_q + TsOne;
        end
`else
        ts_d = ts_q + TsOne;
`endif

        // Packet framing FSM.
        if (accept) begin
            if (state_q == StSop) begin
                stamp_d = ts_q;
            end
            state_d = s_axis.tlast ? StSop : StMid;
        end

        // Buffering; accept is only possible while the skid entry is empty.
        if (skid_vld_q) begin
            if (consume) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || consume) begin
                main_d     = in_beat;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end
        end else if (consume) begin
            main_vld_d = 1'b0;
        end

        rdy_d = ~skid_vld_d;

        if (sw_rst) begin
            ts_d       = '0;
            stamp_d    = '0;
            state_d    = StSop;
            main_d     = '0;
            skid_d     = '0;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            rdy_d      = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ts_q       <= '0;
            stamp_q    <= '0;
            state_q    <= StSop;
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            stamp_q    <= stamp_d;
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_axis.tready = rdy_q;
    assign m_axis.tvalid = main_vld_q;
    assign m_axis.tdata  = main_q.data;
    assign m_axis.tstrb  = main_q.strb;
    assign m_axis.tuser  = main_q.user;
    assign m_axis.tlast  = main_q.last;
    assign ts_now        = ts_q;

endmodule
